// File: rtl/fir_decim_out_stage.sv
// fir_decim_out_stage: decimates the FIR output stream by DECIM and buffers
// the decimated samples in a FIFO drained over a valid/ready handshake.
//
// Optional feature macro: FIR_DECIM_AVG_EN
//   defined   -> boxcar average of each DECIM-sample window (DECIM must be 2^n)
//   undefined -> pick-one decimation (last sample of each window)
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-high
//   in_data     signed filtered sample
//   in_valid    in_data qualifier
//   out_data    signed sample at FIFO head
//   out_valid   FIFO non-empty
//   out_ready   consumer accept
//   fifo_level  current FIFO occupancy
//   overflow    sticky, a decimated sample was dropped
module fir_decim_out_stage #(
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [15:0]                       in_data,
  input  logic                              in_valid,
  output logic [15:0]                       out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned SH = $clog2(DECIM);
  localparam int unsigned PW = (SH == 0) ? 1 : SH;

  logic [PW-1:0] phase;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   mem [FIFO_DEPTH];

  logic          last;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_acc;
  logic [15:0]   push_data;
  logic [LW-1:0] level_next;

  // Window bookkeeping and FIFO handshake decode
  always_comb begin
    last       = (phase == PW'(DECIM - 1));
    push       = in_valid & last;
    pop        = out_valid & out_ready;
    full       = (fifo_level == LW'(FIFO_DEPTH));
    // A pop on the same edge frees the slot the push needs
    push_acc   = push & (~full | pop);
    level_next = fifo_level + LW'(push_acc) - LW'(pop);
  end

`ifdef FIR_DECIM_AVG_EN
  localparam int unsigned ACC_W = 16 + SH;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;

  // Window sum including the current sample; mean is a floor shift
  always_comb begin
    sum       = acc + ACC_W'($signed(in_data));
    push_data = 16'(sum >>> SH);
  end

  // Accumulator restarts at each push event
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (in_valid) begin
      acc <= last ? '0 : sum;
    end
  end
`else
  always_comb begin
    push_data = in_data;
  end
`endif

  // Decimation phase, advances only on valid samples
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= last ? '0 : phase + PW'(1);
    end
  end

  // FIFO storage; entry 0 cleared so out_data reads 0 after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
    end else if (push_acc) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_next;
      out_valid  <= (level_next != '0);
      if (push & ~push_acc) overflow <= 1'b1;
    end
  end

  assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_fir_decim_out_stage.sv
// Randomized and directed bench for fir_decim_out_stage against a queue-based
// reference model (window list + FIFO queue).
module tb_fir_decim_out_stage;

  localparam int unsigned DECIM      = 4;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   in_data;
  logic          in_valid;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  fir_decim_out_stage #(.DECIM(DECIM), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          win[$];
  logic [15:0] mq[$];
  logic        m_ovf;
  logic [15:0] seen[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] window_value();
    int sum;
`ifdef FIR_DECIM_AVG_EN
    sum = 0;
    foreach (win[i]) sum += win[i];
    if (sum >= 0) return 16'(sum / int'(DECIM));
    return 16'(-((-sum + int'(DECIM) - 1) / int'(DECIM)));
`else
    sum = win[win.size() - 1];
    return 16'(sum);
`endif
  endfunction

  // One clock: drive inputs, compare outputs to model, advance model
  task automatic step(input logic v, input logic [15:0] d, input logic r);
    logic        pop;
    logic        do_push;
    logic [15:0] val;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check("out_data", 32'(out_data), 32'(mq[0]));
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (out_valid && r) seen.push_back(out_data);
    pop     = (mq.size() != 0) && r;
    do_push = 1'b0;
    val     = '0;
    if (v) begin
      win.push_back(int'($signed(d)));
      if (win.size() == DECIM) begin
        val = window_value();
        win.delete();
        if (mq.size() < FIFO_DEPTH || pop) do_push = 1'b1;
        else m_ovf = 1'b1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (do_push) mq.push_back(val);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'($urandom);
    in_data   = 16'($urandom);
    out_ready = 1'($urandom);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    win.delete();
    mq.delete();
    m_ovf = 1'b0;
    seen.delete();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), r);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Consecutive 1..8, always ready
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b1);
    idle(3, 1'b1);
    check("seq_count", 32'(seen.size()), 32'd2);
`ifdef FIR_DECIM_AVG_EN
    if (seen.size() == 2) begin check("seq_0", 32'(seen[0]), 32'd2); check("seq_1", 32'(seen[1]), 32'd6); end
`else
    if (seen.size() == 2) begin check("seq_0", 32'(seen[0]), 32'd4); check("seq_1", 32'(seen[1]), 32'd8); end
`endif
    check("seq_overflow", 32'(overflow), 32'd0);

    // Negative window then saturated-positive window
    seen.delete();
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(-i), 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, 16'h7FFF, 1'b1);
    idle(3, 1'b1);
    check("neg_count", 32'(seen.size()), 32'd2);
`ifdef FIR_DECIM_AVG_EN
    if (seen.size() == 2) check("neg_val", 32'(seen[0]), 32'(16'hFFFD));
`else
    if (seen.size() == 2) check("neg_val", 32'(seen[0]), 32'(16'hFFFC));
`endif
    if (seen.size() == 2) check("max_val", 32'(seen[1]), 32'(16'h7FFF));

    // Gapped input, valid every third cycle
    seen.delete();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 16'(10 * i), 1'b1);
      idle(2, 1'b1);
    end
    idle(2, 1'b1);
    check("gap_count", 32'(seen.size()), 32'd1);
`ifdef FIR_DECIM_AVG_EN
    if (seen.size() == 1) check("gap_val", 32'(seen[0]), 32'd25);
`else
    if (seen.size() == 1) check("gap_val", 32'(seen[0]), 32'd40);
`endif

    // Overflow: nine pushes into a stalled FIFO
    do_reset();
    for (int i = 1; i <= 36; i++) step(1'b1, 16'(i), 1'b0);
    idle(1, 1'b0);
    check("ovf_level", 32'(fifo_level), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    idle(12, 1'b1);
    check("ovf_drain_count", 32'(seen.size()), 32'd8);
    if (seen.size() == 8) check("ovf_last", 32'(seen[7]), 32'(window_last(8)));
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO, push coincides with a pop
    do_reset();
    for (int i = 1; i <= 32; i++) step(1'b1, 16'(i), 1'b0);
    for (int i = 33; i <= 35; i++) step(1'b1, 16'(i), 1'b0);
    step(1'b1, 16'd36, 1'b1);
    idle(1, 1'b0);
    check("fullpop_level", 32'(fifo_level), 32'd8);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    idle(10, 1'b1);
    check("fullpop_count", 32'(seen.size()), 32'd9);
    if (seen.size() == 9) check("fullpop_last", 32'(seen[8]), 32'(window_last(9)));

    // Reset mid-window with three entries queued
    do_reset();
    for (int i = 1; i <= 14; i++) step(1'b1, 16'(100 + i), 1'b0);
    idle(1, 1'b0);
    check("mid_level_pre", 32'(fifo_level), 32'd3);
    do_reset();
    for (int i = 5; i <= 8; i++) step(1'b1, 16'(i), 1'b1);
    idle(2, 1'b1);
    check("mid_count", 32'(seen.size()), 32'd1);
`ifdef FIR_DECIM_AVG_EN
    if (seen.size() == 1) check("mid_val", 32'(seen[0]), 32'd6);
`else
    if (seen.size() == 1) check("mid_val", 32'(seen[0]), 32'd8);
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) == 0 ? 0 : $urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Expected value of the k-th window when inputs are 1,2,3,... in order
  function automatic int window_last(input int k);
`ifdef FIR_DECIM_AVG_EN
    return 4 * k - 2;
`else
    return 4 * k;
`endif
  endfunction

endmodule

// File: doc/fir_decim_out_stage.md
# fir_decim_out_stage

Downstream stage for the 16-bit FIR filter output. It decimates the filtered sample stream by a fixed factor and buffers the decimated samples in a small FIFO. The FIFO drains through a valid/ready handshake toward the DAC/AXI-stream output path. Input samples are qualified by the same `valid` strobe that advances the FIR delay line.

## Interface
- `DECIM`, default 4: decimation factor, 1..64. Must be a power of two when `FIR_DECIM_AVG_EN` is defined.
- `FIFO_DEPTH`, default 8: FIFO entries, power of two, 2..64.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  16  signed filtered sample (FIR `d_out`).
- `in_valid`  in  1  `in_data` qualifier, one sample per high cycle.
- `out_data`  out  16  signed decimated sample at FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid & out_ready`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky; a decimated sample was dropped.

## Operation
- Phase counter `phase` runs 0..DECIM-1.
  - Advances only on `in_valid`.
  - Wraps DECIM-1 -> 0.
  - Holds through `in_valid` gaps.
- Push event: `in_valid` while `phase == DECIM-1`.
  - DECIM=1 means every valid input is a push.
- Sample selection without averaging: the pushed value is the `in_data` present at the push event. The other DECIM-1 samples are discarded.
- Pop: `out_valid & out_ready`. The head advances and `fifo_level` decrements.
- Push acceptance: accepted when `fifo_level < FIFO_DEPTH`, or when a pop occurs in the same cycle.
  - Full with no pop: the sample is dropped, `overflow` <= 1, and FIFO contents and level are unchanged.
- Simultaneous push and pop: `fifo_level` unchanged, write and read pointers both advance.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
- `out_data` = memory[read pointer]. It is stable while `out_valid & !out_ready`.
- `overflow` clears only on `reset`.
- Reset values:
  - `phase`, pointers and `fifo_level` = 0.
  - `out_valid` = 0, `overflow` = 0.
  - `out_data` = 0: memory entry 0 is cleared.
  - Accumulator = 0.
- Reset mid-operation: a partial decimation window is discarded, FIFO contents are discarded, and the next valid input after reset is phase 0.
- The FIR startup transient is not masked here. The first decimated outputs contain the filter warm-up.

## Timing
- Push is written on the clock edge of the push event.
- `out_valid` and `out_data` reflect the new entry in the following cycle, even when the FIFO was empty: 1-cycle latency.
- Pop takes effect on the edge where `out_valid & out_ready`. The next head appears the following cycle.
- `fifo_level` and `overflow` are registered and update on the same edge as the triggering event.
- Full throughput: one push and one pop per cycle, sustained.

## Configuration
- `FIR_DECIM_AVG_EN` defined: boxcar-average mode.
  - A (16+log2(DECIM))-bit signed accumulator sums all DECIM valid inputs of the window.
  - At the push event, the pushed value is (acc + in_data) >>> log2(DECIM): arithmetic shift, floor rounding, always fits 16 bits.
  - The accumulator then restarts at 0.
- `FIR_DECIM_AVG_EN` undefined: pick-one decimation, no accumulator hardware.

## Test plan
- Pick-one: DECIM=4, in_data 1..8 on consecutive cycles, `out_ready`=1 -> outputs 4 then 8, each one cycle after its push, `overflow`=0.
- Average (`FIR_DECIM_AVG_EN`): DECIM=4, inputs 1..8 -> outputs 2 (10>>>2), 6 (26>>>2). Inputs -1,-2,-3,-4 -> -3. Inputs 32767 ×4 -> 32767.
- Gapped input: DECIM=4, `in_valid` high every third cycle with values 10,20,30,40 -> single output 40 (avg mode: 25); `phase` holds across gaps.
- Backpressure/overflow: FIFO_DEPTH=8, `out_ready`=0, 9 push events -> `fifo_level`=8, `overflow`=1. Draining returns the first 8 samples in order, the 9th is absent, and `overflow` stays 1.
- Full plus simultaneous pop: FIFO full, push event coincides with `out_ready`=1 -> push accepted, `fifo_level` stays 8, `overflow` stays 0, new sample appears last in drain order.
- Reset mid-window: DECIM=4, 2 inputs, `reset` pulse with FIFO holding 3 entries -> `out_valid`=0, `fifo_level`=0. The next 4 inputs 5,6,7,8 -> output 8 (avg: 6).
